// File: rtl/instr_encoder.sv
// RV32I instruction-word producer: encodes field-level requests into 32-bit
// machine words and streams them to the instruction-memory write port.
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [20:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic              err,
    output logic [15:0]       word_count,
    output logic [7:0]        err_count,
    output logic              wrapped
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (DEPTH - 1));

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_q, err_d;
    logic [15:0]       word_count_q, word_count_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              wrapped_q, wrapped_d;

    logic        accept, complete;
    logic        fits12, fits13;
    logic [31:0] enc_word;
    logic        enc_bad;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = out_valid_q && out_ready;

    // Sign-extension test: all bits above the field's sign bit must match it.
    assign fits12 = (in_imm[20:11] == {10{in_imm[11]}});
    assign fits13 = (in_imm[20:12] == {9{in_imm[12]}});

    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        case (in_type)
            3'd0: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
                enc_bad  = !fits12;
            end
            3'd1: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
                enc_bad  = !fits12;
            end
            3'd2: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
            end
            3'd3: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OP_BRANCH};
                enc_bad  = !fits13 || in_imm[0];
            end
            3'd4: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ITYPE};
                enc_bad  = !fits12;
            end
            3'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                enc_bad  = in_imm[0];
            end
            default: begin
                enc_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;
        err_d        = accept && enc_bad;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        wrapped_d    = wrapped_q;

        if (complete) begin
            out_valid_d = 1'b0;
            if (out_addr_q == LAST_ADDR) begin
                out_addr_d = BASE_ADDR;
                wrapped_d  = 1'b1;
            end else begin
                out_addr_d = out_addr_q + ADDR_W'(4);
            end
            if (word_count_q != 16'hFFFF) begin
                word_count_d = word_count_q + 16'd1;
            end
        end

        // A new word lands at the already-advanced address, so no bubble.
        if (accept && !enc_bad) begin
            out_valid_d = 1'b1;
            out_data_d  = enc_word;
        end

        if (accept && enc_bad && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= BASE_ADDR;
            err_q        <= 1'b0;
            word_count_q <= '0;
            err_count_q  <= '0;
            wrapped_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
            wrapped_q    <= wrapped_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign err        = err_q;
    assign word_count = word_count_q;
    assign err_count  = err_count_q;
    assign wrapped    = wrapped_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Instruction-word producer for the single-cycle RISC-V core. It assembles 32-bit RV32I machine words from field-level requests and streams them into the instruction-memory write port.
- It covers exactly the opcode classes the core's main control decoder consumes: LOAD, STORE, R-type, BRANCH, I-type ALU and JAL.
- Used by the program loader and the self-test bench to fill instruction memory before the core is released from reset.
- One valid/ready input, one registered valid/ready output, an auto-incrementing write address, and range/format error checking.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- BASE_ADDR, 0, first byte address written after reset or clear.
- DEPTH, 64, number of 32-bit words in the target memory. The address wraps after DEPTH words. Must be at least 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous; returns the address to BASE_ADDR and zeroes the counters
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_type  in  3  0=LOAD, 1=STORE, 2=RTYPE, 3=BRANCH, 4=ITYPE, 5=JAL, 6/7=illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (RTYPE only)
- in_imm  in  21  signed immediate, byte offset
- out_valid  out  1  memory write pending
- out_ready  in  1  memory accepts the write this cycle
- out_addr  out  ADDR_W  byte address of the write
- out_data  out  32  encoded instruction
- err  out  1  one-cycle pulse: the request accepted in the previous cycle was rejected
- word_count  out  16  number of words delivered (saturates at 0xFFFF)
- err_count  out  8  number of rejected requests (saturates at 0xFF)
- wrapped  out  1  sticky: the address has wrapped at least once

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_addr=BASE_ADDR, err=0, word_count=0, err_count=0, wrapped=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides a pending write: the pending word is dropped and not counted.
- clear: same effect as reset. If rst and clear are asserted together, rst wins; the result is identical.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register).
  - Latency is 1 cycle: a request accepted at edge N appears on out_valid/out_data after edge N.
  - With out_ready held at 1, throughput is one word per cycle.
  - While out_valid=1 && out_ready=0: out_data and out_addr hold stable and in_ready=0.
- Encoding:
  - LOAD (opcode 0000011), I-format: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - ITYPE (0010011): same I-format layout as LOAD.
  - STORE (0100011), S-format: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - RTYPE (0110011): [31:25]=funct7, [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - BRANCH (1100011), B-format: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; rs2/rs1/funct3 as in S-format.
  - JAL (1101111), J-format: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
  - Fields not used by a class are ignored.
- Rejection rules (the request is still accepted, i.e. it consumes the handshake):
  - in_type is 6 or 7.
  - I/S immediate outside the range -2048..2047.
  - B immediate outside -4096..4094, or imm[0]=1.
  - J immediate has imm[0]=1. A 21-bit input always fits in range.
  - A rejected request produces no write and leaves the address unchanged. err pulses in the cycle after acceptance (same cycle a valid word would have appeared) and err_count increments.
- Address:
  - Advances by 4 on each completed write (out_valid && out_ready).
  - After the word at BASE_ADDR+4*(DEPTH-1), the next address is BASE_ADDR and wrapped is set.
  - word_count increments on each completed write.
- Simultaneous events: a completion and a new acceptance in the same cycle load the next word at the already-advanced address with no bubble.

Test Plan:
- Reset, then LOAD rd=5, rs1=2, funct3=010, imm=8 with out_ready=1 -> next cycle out_valid=1, out_data=0x00812283, out_addr=0x0.
- STORE rs2=6, rs1=2, funct3=010, imm=12; then RTYPE rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x00612623 at address 0x0, then 0x002081B3 at address 0x4, back-to-back with no bubble.
- BRANCH rs1=1, rs2=2, funct3=000, imm=8, then JAL rd=1, imm=16 -> 0x00208463, then 0x010000EF. Hold out_ready=0 for 3 cycles on the first word -> data and address stable, in_ready=0, no loss.
- Error cases:
  - ITYPE imm=2048 -> no out_valid, err pulses once, err_count=1.
  - BRANCH imm=3 -> err_count=2.
  - in_type=7 -> err_count=3.
  - word_count and address are unchanged throughout.
- DEPTH=4, write 5 valid words -> addresses 0, 4, 8, 12, 0; wrapped=1 after the 4th completion; word_count=5.
- Assert rst while out_valid=1 && out_ready=0 -> next cycle out_valid=0, out_addr=BASE_ADDR, all counters 0, in_ready=1.
